muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for HI/LO ops in the EX stage: owns HI/LO, runs multi-cycle MULT/MULTU/DIV/DIVU,
//  performs MTHI/MTLO, stalls the pipeline while busy, aborts on flush. Replaces the single-cycle
//  multiply and the free-running divider handshake in the ALU.
// PARAMETERS
//  MUL_LAT   2   multiply latency in cycles (pipelined product, >=1)
//  DIV_CYC   33  divide latency: 1 setup + 32 iterations (fixed by muldiv_div_iter)
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   async reset, active-high
//  req_valid_i  in   1   EX holds a HI/LO instruction; held stable while stall_o=1
//  req_op_i     in   4   muldiv_op_e: 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MADD 7 MADDU 8 MSUB 9 MSUBU
//  rs_i         in   32  operand A / dividend / MTxx source
//  rt_i         in   32  operand B / divisor
//  flush_i      in   1   abort current op (exception/branch flush)
//  stall_o      out  1   hold IF..EX this cycle
//  busy_o       out  1   state != IDLE
//  done_o       out  1   1-cycle pulse: HI/LO written at end of this cycle
//  hi_o         out  32  HI register
//  lo_o         out  32  LO register
// BEHAVIOUR
//  Reset: state IDLE; hi_o=lo_o=0; done_o=0; stall_o=0; busy_o=0; divider cleared.
//  FSM: IDLE -> MUL | DIV -> IDLE. An op is accepted only in IDLE with req_valid_i=1 and flush_i=0.
//  Accept cycle = 0; finish cycle N = MUL_LAT (mul), DIV_CYC (div), 1 (div by zero).
//  stall_o=1 in cycles 0..N-1, 0 in cycle N; done_o=1 in cycle N; new HI/LO visible cycle N+1.
//  Finish cycle is in a busy state, so the still-asserted req is not re-accepted; next IDLE cycle's
//  req is the next instruction.
//  MTHI/MTLO: written at end of accept cycle, no stall, done_o=1 that cycle, other reg unchanged.
//  Illegal op codes: ignored, no stall, no write.
//  MULT: 64-bit signed product of sign-extended 33-bit operands; MULTU: zero-extended. {hi,lo}=prod.
//  DIV/DIVU: lo=quotient, hi=remainder; signed: quotient truncates toward zero, remainder takes
//   dividend sign. 0x80000000 / 0xFFFFFFFF (DIV) -> lo=0x80000000, hi=0.
//  Divisor 0: finish at cycle 1, HI/LO unchanged, done_o=1.
//  flush_i=1: combinationally forces stall_o=0 and done_o=0; busy state -> IDLE next cycle;
//   HI/LO never written (including finish cycle); divider/mul pipe discarded.
//  Reset mid-op: immediate IDLE, HI/LO=0.
// CONFIGURATION
//  MULDIV_ACC_EN defined: MADD/MADDU/MSUB/MSUBU legal; {hi,lo} +/- product (mod 2^64),
//   finish at MUL_LAT+1. Not defined: codes 6..9 illegal (ignored, no stall, no write).
// STRUCTURE
//  muldiv_pkg: muldiv_op_e, muldiv_state_e, DIV_CYC constant, op-class helper functions.
//  Sub-module muldiv_div_iter: radix-2 restoring divider on unsigned magnitudes; start/abort in,
//   quotient/remainder/valid out. Sign fix-up in muldiv_ctrl.
// TESTING
//  MULT 0xFFFFFFFE*3 (MUL_LAT=2) -> stall 2 cycles, hi=0xFFFFFFFF lo=0xFFFFFFFA, done_o cycle 2.
//  DIV -7/2 -> stall 33 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/2 -> lo=3 hi=1.
//  DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU x/0 -> done cycle 1, HI/LO unchanged.
//  DIV with flush_i at cycle 10 -> stall_o=0 same cycle, no done_o, HI/LO unchanged, next req accepted.
//  MTHI 0x12345678 then MTLO 0x9 back-to-back -> no stall, hi=0x12345678 lo=0x9.
//  ACC_EN: hi=0,lo=0xFFFFFFFF; MADDU 1*1 -> hi=1 lo=0 at cycle MUL_LAT+1; undefined: MADD ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-class helpers for the HI/LO sequencer.
// Define MULDIV_ACC_EN to make MADD/MADDU/MSUB/MSUBU legal; otherwise codes 6..9 are ignored.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } muldiv_state_e;

    localparam int DIV_CYC = 33;

`ifdef MULDIV_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    function automatic logic is_acc_op(input logic [3:0] op);
        return ACC_EN && ((op == OP_MADD) || (op == OP_MADDU) ||
                          (op == OP_MSUB) || (op == OP_MSUBU));
    endfunction

    function automatic logic is_sub_op(input logic [3:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || is_acc_op(op);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mt_op(input logic [3:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider on unsigned 32-bit magnitudes: start loads the operands,
// then one quotient bit per cycle; valid is high for the cycle after the last iteration.
module muldiv_div_iter
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        valid_o
);

    localparam logic [5:0] LAST_ITER = 6'(DIV_CYC - 1);

    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic [5:0]  cnt_r;
    logic        active_r;
    logic [32:0] shift_s;
    logic [32:0] diff_s;
    logic [31:0] rem_nx_s;
    logic [31:0] quo_nx_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shift_s  = {rem_r, quo_r[31]};
        diff_s   = shift_s - {1'b0, dvs_r};
        rem_nx_s = rem_r;
        quo_nx_s = quo_r;
        if (diff_s[32]) begin
            rem_nx_s = shift_s[31:0];
            quo_nx_s = {quo_r[30:0], 1'b0};
        end else begin
            rem_nx_s = diff_s[31:0];
            quo_nx_s = {quo_r[30:0], 1'b1};
        end
    end

    // Iteration registers and step counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_r    <= 32'd0;
            quo_r    <= 32'd0;
            dvs_r    <= 32'd0;
            cnt_r    <= 6'd0;
            active_r <= 1'b0;
        end else if (abort_i) begin
            cnt_r    <= 6'd0;
            active_r <= 1'b0;
        end else if (start_i) begin
            rem_r    <= 32'd0;
            quo_r    <= dividend_i;
            dvs_r    <= divisor_i;
            cnt_r    <= 6'd0;
            active_r <= 1'b1;
        end else if (active_r && (cnt_r != LAST_ITER)) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            cnt_r <= cnt_r + 6'd1;
        end else begin
            active_r <= 1'b0;
        end
    end

    assign quotient_o  = quo_r;
    assign remainder_o = rem_r;
    assign valid_o     = active_r && (cnt_r == LAST_ITER);

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: owns HI/LO, runs multi-cycle multiply/divide, stalls while busy.
// Define MULDIV_ACC_EN to enable the multiply-accumulate ops (finish at MUL_LAT+1).
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [3:0]  req_op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    muldiv_state_e state_r, state_nx_s;
    logic [7:0]  cnt_r;
    logic [3:0]  op_r;
    logic [31:0] a_r, b_r;
    logic        dz_r, neg_q_r, neg_r_r;
    logic [31:0] hi_r, lo_r, hi_nx_s, lo_nx_s;

    logic        accept_s, acc_mul_s, acc_div_s, acc_mt_s;
    logic        div_sgn_s, div_start_s, div_valid_s;
    logic [31:0] a_mag_s, b_mag_s, quo_s, rem_s, quo_fix_s, rem_fix_s;
    logic        mul_sgn_s, finish_s, stall_s, done_s;
    logic [7:0]  mul_fin_s;
    logic [63:0] a64_s, b64_s, prod_s, mul_res_s;

    assign accept_s  = (state_r == ST_IDLE) && req_valid_i && !flush_i;
    assign acc_mul_s = accept_s && is_mul_op(req_op_i);
    assign acc_div_s = accept_s && is_div_op(req_op_i);
    assign acc_mt_s  = accept_s && is_mt_op(req_op_i);

    assign div_sgn_s   = is_signed_op(req_op_i);
    assign a_mag_s     = (div_sgn_s && rs_i[31]) ? (32'd0 - rs_i) : rs_i;
    assign b_mag_s     = (div_sgn_s && rt_i[31]) ? (32'd0 - rt_i) : rt_i;
    assign div_start_s = acc_div_s && (rt_i != 32'd0);

    muldiv_div_iter u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start_s),
        .abort_i     (flush_i && (state_r == ST_DIV)),
        .dividend_i  (a_mag_s),
        .divisor_i   (b_mag_s),
        .quotient_o  (quo_s),
        .remainder_o (rem_s),
        .valid_o     (div_valid_s)
    );

    assign quo_fix_s = neg_q_r ? (32'd0 - quo_s) : quo_s;
    assign rem_fix_s = neg_r_r ? (32'd0 - rem_s) : rem_s;

    // Low 64 bits of the product are the same for 33-bit and 64-bit extended operands.
    assign mul_sgn_s = is_signed_op(op_r);
    assign a64_s     = {{32{mul_sgn_s && a_r[31]}}, a_r};
    assign b64_s     = {{32{mul_sgn_s && b_r[31]}}, b_r};
    assign prod_s    = a64_s * b64_s;
    assign mul_fin_s = is_acc_op(op_r) ? 8'(MUL_LAT + 1) : 8'(MUL_LAT);

    // Multiply result, optionally folded into the current HI/LO.
    always_comb begin
        mul_res_s = prod_s;
        if (!is_acc_op(op_r)) begin
            mul_res_s = prod_s;
        end else if (is_sub_op(op_r)) begin
            mul_res_s = {hi_r, lo_r} - prod_s;
        end else begin
            mul_res_s = {hi_r, lo_r} + prod_s;
        end
    end

    // Finish-cycle detection per busy state.
    always_comb begin
        finish_s = 1'b0;
        case (state_r)
            ST_MUL: finish_s = (cnt_r == mul_fin_s);
            ST_DIV: begin
                if (dz_r) begin
                    finish_s = (cnt_r == 8'd1);
                end else begin
                    finish_s = div_valid_s;
                end
            end
            default: finish_s = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_mul_s) begin
                    state_nx_s = ST_MUL;
                end else if (acc_div_s) begin
                    state_nx_s = ST_DIV;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush_i || finish_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Stall, done and HI/LO update; a flush suppresses both outputs and any write.
    always_comb begin
        stall_s = 1'b0;
        done_s  = 1'b0;
        hi_nx_s = hi_r;
        lo_nx_s = lo_r;
        if (state_r == ST_IDLE) begin
            if (acc_mul_s || acc_div_s) begin
                stall_s = 1'b1;
            end else if (acc_mt_s) begin
                done_s = 1'b1;
                if (req_op_i == OP_MTHI) begin
                    hi_nx_s = rs_i;
                end else begin
                    lo_nx_s = rs_i;
                end
            end else begin
                stall_s = 1'b0;
            end
        end else if (flush_i) begin
            stall_s = 1'b0;
        end else if (finish_s) begin
            done_s = 1'b1;
            if (state_r == ST_MUL) begin
                {hi_nx_s, lo_nx_s} = mul_res_s;
            end else if (!dz_r) begin
                hi_nx_s = rem_fix_s;
                lo_nx_s = quo_fix_s;
            end else begin
                hi_nx_s = hi_r;
            end
        end else begin
            stall_s = 1'b1;
        end
    end

    // State, cycle counter and HI/LO registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_nx_s;
            hi_r    <= hi_nx_s;
            lo_r    <= lo_nx_s;
            if (state_nx_s == ST_IDLE) begin
                cnt_r <= 8'd0;
            end else if (state_r == ST_IDLE) begin
                cnt_r <= 8'd1;
            end else begin
                cnt_r <= cnt_r + 8'd1;
            end
        end
    end

    // Operand capture on accept of a multi-cycle op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_r    <= 4'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            dz_r    <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (acc_mul_s || acc_div_s) begin
            op_r    <= req_op_i;
            a_r     <= rs_i;
            b_r     <= rt_i;
            dz_r    <= acc_div_s && (rt_i == 32'd0);
            neg_q_r <= div_sgn_s && (rs_i[31] ^ rt_i[31]);
            neg_r_r <= div_sgn_s && rs_i[31];
        end else begin
            op_r <= op_r;
        end
    end

    assign stall_o = stall_s;
    assign done_o  = done_s;
    assign busy_o  = (state_r != ST_IDLE);
    assign hi_o    = hi_r;
    assign lo_o    = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed table-driven bench for muldiv_ctrl plus flush and reset corner sequences.
module tb_muldiv_ctrl;

    localparam int LAT = 2;
    localparam int DCY = 33;
    localparam int NV  = 15;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          done_cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] rs, rt;
    logic        flush;
    logic        stall_o, busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[NV];
    logic [31:0] exp_hi, exp_lo;

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_op_i    (req_op),
        .rs_i        (rs),
        .rt_i        (rt),
        .flush_i     (flush),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one request just after a rising edge, holds it until stall drops.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int stall_cnt, output int done_cnt);
        logic st;
        req_valid = 1'b1;
        req_op    = op;
        rs        = a;
        rt        = b;
        done_cyc  = -1;
        stall_cnt = 0;
        done_cnt  = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            st = stall_o;
            if (stall_o) stall_cnt++;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk);
            #1;
            if (!st) break;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int dc, sc, dn, cnt;

        vecs[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, LAT};
        vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, LAT};
        vecs[2]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DCY};
        vecs[3]  = '{4'd3, 32'd7,        32'd2,        32'd1,        32'd3,        DCY};
        vecs[4]  = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DCY};
        vecs[5]  = '{4'd3, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, DCY};
        vecs[6]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DCY};
        vecs[7]  = '{4'd3, 32'd5,        32'd0,        32'd0,        32'h80000000, 1};
        vecs[8]  = '{4'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h80000000, 0};
        vecs[9]  = '{4'd5, 32'd9,        32'd0,        32'h12345678, 32'd9,        0};
        vecs[10] = '{4'd15, 32'd1,       32'd1,        32'h12345678, 32'd9,        -1};
        vecs[11] = '{4'd4, 32'd0,        32'd0,        32'd0,        32'd9,        0};
        vecs[12] = '{4'd5, 32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 0};
`ifdef MULDIV_ACC_EN
        vecs[13] = '{4'd7, 32'd1,        32'd1,        32'd1,        32'd0,        LAT + 1};
        vecs[14] = '{4'd6, 32'd2,        32'd3,        32'd1,        32'd6,        LAT + 1};
`else
        vecs[13] = '{4'd7, 32'd1,        32'd1,        32'd0,        32'hFFFFFFFF, -1};
        vecs[14] = '{4'd6, 32'd2,        32'd3,        32'd0,        32'hFFFFFFFF, -1};
`endif

        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; rs = 32'd0; rt = 32'd0; flush = 1'b0;
        @(negedge clk);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, dc, sc, dn);
            chk($sformatf("v%0d_done_cyc", i), 64'(dc), 64'(vecs[i].done_cyc));
            chk($sformatf("v%0d_stall_cyc", i), 64'(sc),
                64'((vecs[i].done_cyc < 0) ? 0 : vecs[i].done_cyc));
            chk($sformatf("v%0d_done_cnt", i), 64'(dn), 64'((vecs[i].done_cyc < 0) ? 0 : 1));
            chk($sformatf("v%0d_hi", i), 64'(hi_o), 64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(lo_o), 64'(vecs[i].lo));
            chk($sformatf("v%0d_busy", i), 64'(busy_o), 64'd0);
        end
        exp_hi = vecs[NV-1].hi;
        exp_lo = vecs[NV-1].lo;

        // DIV flushed at cycle 10
        req_valid = 1'b1; req_op = 4'd2; rs = 32'hFFFFFFF9; rt = 32'd2;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_div_stall", 64'(stall_o), 64'd0);
        chk("flush_div_done", 64'(done_o), 64'd0);
        chk("flush_div_busy_pre", 64'(busy_o), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_div_idle", 64'(busy_o), 64'd0);
        cnt = 0;
        repeat (40) begin @(negedge clk); if (done_o) cnt++; end
        chk("flush_div_no_done", 64'(cnt), 64'd0);
        chk("flush_div_hi", 64'(hi_o), 64'(exp_hi));
        chk("flush_div_lo", 64'(lo_o), 64'(exp_lo));
        @(posedge clk); #1;
        run_op(4'd5, 32'h55, 32'd0, dc, sc, dn);
        chk("post_flush_done", 64'(dc), 64'd0);
        chk("post_flush_lo", 64'(lo_o), 64'h55);
        exp_lo = 32'h55;

        // MULTU flushed in its finish cycle
        req_valid = 1'b1; req_op = 4'd1; rs = 32'd5; rt = 32'd5;
        repeat (LAT) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_mul_done", 64'(done_o), 64'd0);
        chk("flush_mul_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_mul_busy", 64'(busy_o), 64'd0);
        chk("flush_mul_hi", 64'(hi_o), 64'(exp_hi));
        chk("flush_mul_lo", 64'(lo_o), 64'(exp_lo));
        @(posedge clk); #1;

        // reset in the middle of a divide
        req_valid = 1'b1; req_op = 4'd3; rs = 32'd100; rt = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        chk("mid_busy_before_rst", 64'(busy_o), 64'd1);
        #2;
        rst = 1'b1; req_valid = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_stall", 64'(stall_o), 64'd0);
        chk("mid_rst_hi", 64'(hi_o), 64'd0);
        chk("mid_rst_lo", 64'(lo_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(4'd0, 32'hFFFFFFFE, 32'd3, dc, sc, dn);
        chk("rec_done_cyc", 64'(dc), 64'(LAT));
        chk("rec_hi", 64'(hi_o), 64'hFFFFFFFF);
        chk("rec_lo", 64'(lo_o), 64'hFFFFFFFA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
